imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate decoder for the RV32I/RV64I decode path.
- Successor to the combinational immediate generator, parametrised in XLEN.
- Adds AUIPC, JALR, shift-amount and CSR zimm formats, an illegal-opcode flag, a 2-entry skid buffer with valid/ready on both sides, and a saturating illegal-instruction counter.
- Sits between instruction fetch and the register-read/execute stage.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  consumer accepts entry this cycle.
- out_instr  output  32  instruction word carried with the immediate.
- out_imm  output  XLEN  decoded immediate, signed unless noted.
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_illegal  output  1  opcode not in the supported set.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n=0 at posedge): buffer emptied, out_valid=0, in_ready=1, out_instr=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0. Reset mid-transfer discards buffered entries without emitting them.
- Decode, opcode = instr[6:0]:
  - 0010011 with funct3 = 001 or 101: SHAMT, zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 0010011 otherwise, 0000011, 1100111: I, sext(instr[31:20]).
  - 0100011: S, sext({instr[31:25], instr[11:7]}).
  - 1100011: B, sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111: U, sext({instr[31:12], 12'b0}). Sign-extends to 64 when XLEN=64.
  - 1101111: J, sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 1110011 with funct3[2]=1: ZIMM, zero-extended instr[19:15].
  - 1110011 with funct3[2]=0: NONE, imm 0.
  - 0110011, 0001111: NONE, imm 0.
  - Any other opcode: NONE, imm 0, illegal=1.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Decode is performed at input and the result is registered, so latency is 1 cycle from input transfer to out_valid.
- Buffer:
  - 2-entry FIFO (primary + skid). Output presents the oldest entry.
  - in_ready = (count < 2); it is registered, with no combinational path from out_ready.
  - Count update: +1 on input-only transfer, -1 on output-only transfer, unchanged on simultaneous transfer.
  - A simultaneous input and output transfer at count=1 replaces the output with the new entry next cycle.
  - At count=2, in_ready=0; in_valid is ignored and no state changes from the input side.
  - out_valid=1 whenever count>0.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- illegal_cnt:
  - Increments by 1 on each input transfer whose decode is illegal.
  - Saturates at all-ones.
  - Counts at acceptance, not emission.
- in_instr is don't-care when in_valid=0; no X propagates into state.

Test Plan:
- XLEN=32, send 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- XLEN=64, send 0x800002B7 (lui, imm 0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=4. Send 0x00000517 (auipc) -> imm 0, fmt=4.
- Send B-type 0xFE000EE3 -> out_imm=-4 (0xFFFFFFFC), fmt=3. Send J-type 0x0080006F -> imm 8, fmt=5. Send slli 0x01F09093 -> imm 31, fmt=6. Send csrrwi 0x3401D073 -> imm 3, fmt=7.
- Hold out_ready=0 and offer 3 instructions back-to-back -> first two accepted, in_ready=0 from cycle 2, third held. Raise out_ready -> entries emitted in order with no loss or duplication.
- Send opcode 0x7F three times with CNT_W=2 -> out_illegal=1 each, illegal_cnt goes 1, 2, 3. Send a fourth -> illegal_cnt stays 3.
- With 2 entries buffered, assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, illegal_cnt=0 the following cycle, and neither buffered entry is emitted.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I/RV64I immediate decoder.
// Decode happens on the input transfer. The result lands in a 2-entry
// buffer: a primary slot that drives the outputs directly, and a skid slot
// behind it. in_ready is registered, so there is no combinational path
// from out_ready back to in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Immediate decode of the offered word; only consumed on an input transfer.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_fmt = FMT_ZIMM;
          dec_imm = XLEN'(in_instr[19:15]);
        end
      end
      7'b0110011, 7'b0001111: ;
      default: dec_ill = 1'b1;
    endcase
  end

  logic [1:0]      count, count_nxt;
  logic            in_fire, out_fire;
  logic [31:0]     sk_instr;
  logic [XLEN-1:0] sk_imm;
  logic [2:0]      sk_fmt;
  logic            sk_ill;

  assign out_valid = (count != 2'd0);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    if (in_fire && !out_fire)      count_nxt = count + 2'd1;
    else if (out_fire && !in_fire) count_nxt = count - 2'd1;
  end

  // Buffer, ready flag and illegal counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= 2'd0;
      in_ready    <= 1'b1;
      out_instr   <= '0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
      sk_instr    <= '0;
      sk_imm      <= '0;
      sk_fmt      <= FMT_NONE;
      sk_ill      <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (in_fire && dec_ill && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      // New entry goes straight to the output slot when it is (or becomes) free.
      if (in_fire && (count == 2'd0 || (count == 2'd1 && out_fire))) begin
        out_instr   <= in_instr;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_ill;
      end else if (out_fire && count == 2'd2) begin
        out_instr   <= sk_instr;
        out_imm     <= sk_imm;
        out_fmt     <= sk_fmt;
        out_illegal <= sk_ill;
      end
      // Output slot occupied and not draining: park the new entry in the skid.
      if (in_fire && count == 2'd1 && !out_fire) begin
        sk_instr <= in_instr;
        sk_imm   <= dec_imm;
        sk_fmt   <= dec_fmt;
        sk_ill   <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, and CNT_W=2)
// share one stimulus stream. A queue of accepted words, decoded with plain
// arithmetic, is the reference for every output.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        a_ir, a_ov, a_ill;  logic [31:0] a_ins, a_imm; logic [2:0] a_fmt; logic [15:0] a_cnt;
  logic        b_ir, b_ov, b_ill;  logic [31:0] b_ins; logic [63:0] b_imm; logic [2:0] b_fmt; logic [15:0] b_cnt;
  logic        c_ir, c_ov, c_ill;  logic [31:0] c_ins, c_imm; logic [2:0] c_fmt; logic [1:0] c_cnt;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .out_valid(a_ov), .out_ready(out_ready), .out_instr(a_ins), .out_imm(a_imm),
    .out_fmt(a_fmt), .out_illegal(a_ill), .illegal_cnt(a_cnt));
  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
    .in_instr(in_instr), .out_valid(b_ov), .out_ready(out_ready), .out_instr(b_ins), .out_imm(b_imm),
    .out_fmt(b_fmt), .out_illegal(b_ill), .illegal_cnt(b_cnt));
  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) uc2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ir),
    .in_instr(in_instr), .out_valid(c_ov), .out_ready(out_ready), .out_instr(c_ins), .out_imm(c_imm),
    .out_fmt(c_fmt), .out_illegal(c_ill), .illegal_cnt(c_cnt));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] q[$];
  longint cnt16 = 0;
  longint cnt2 = 0;
  bit fresh = 1'b1;

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decode from the format rules; result is the full 64-bit value,
  // truncated to 32 bits for XLEN=32.
  function automatic void ref_dec(input logic [31:0] i, input int xl,
                                  output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint v = 0;
    int f3 = int'(i[14:12]);
    fmt = 3'd0; ill = 1'b0;
    case (i[6:0])
      7'h13: if (f3 == 1 || f3 == 5) begin
               fmt = 3'd6; v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
             end else begin
               fmt = 3'd1; v = sx(longint'(i[31:20]), 12);
             end
      7'h03, 7'h67: begin fmt = 3'd1; v = sx(longint'(i[31:20]), 12); end
      7'h23: begin fmt = 3'd2; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
      7'h63: begin
               fmt = 3'd3;
               v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                      + longint'(i[11:8]) * 2, 13);
             end
      7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'(i[31:12]) * 4096, 32); end
      7'h6F: begin
               fmt = 3'd5;
               v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2, 21);
             end
      7'h73: if (f3 >= 4) begin fmt = 3'd7; v = longint'(i[19:15]); end
      7'h33, 7'h0F: ;
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
    if (xl == 32) imm = {32'b0, imm[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all three instances against the queue model.
  task automatic check_all();
    logic [63:0] e32, e64; logic [2:0] f; logic il;
    bit nz = (q.size() > 0);
    chk("a_out_valid", 64'(a_ov), 64'(nz));
    chk("b_out_valid", 64'(b_ov), 64'(nz));
    chk("c_out_valid", 64'(c_ov), 64'(nz));
    chk("a_in_ready", 64'(a_ir), 64'(q.size() < 2));
    chk("b_in_ready", 64'(b_ir), 64'(q.size() < 2));
    chk("c_in_ready", 64'(c_ir), 64'(q.size() < 2));
    chk("a_illegal_cnt", 64'(a_cnt), 64'(cnt16));
    chk("b_illegal_cnt", 64'(b_cnt), 64'(cnt16));
    chk("c_illegal_cnt", 64'(c_cnt), 64'(cnt2));
    if (nz) begin
      ref_dec(q[0], 32, e32, f, il);
      ref_dec(q[0], 64, e64, f, il);
      chk("a_out_instr", 64'(a_ins), 64'(q[0]));
      chk("b_out_instr", 64'(b_ins), 64'(q[0]));
      chk("a_out_imm", 64'(a_imm), e32);
      chk("b_out_imm", b_imm, e64);
      chk("c_out_imm", 64'(c_imm), e32);
      chk("a_out_fmt", 64'(a_fmt), 64'(f));
      chk("b_out_fmt", 64'(b_fmt), 64'(f));
      chk("a_out_illegal", 64'(a_ill), 64'(il));
      chk("c_out_illegal", 64'(c_ill), 64'(il));
    end else if (fresh) begin
      chk("rst_out_instr", 64'(a_ins), 64'd0);
      chk("rst_out_imm", b_imm, 64'd0);
      chk("rst_out_fmt", 64'(b_fmt), 64'd0);
      chk("rst_out_illegal", 64'(a_ill), 64'd0);
    end
  endtask

  // Drive one cycle from a negedge, update the model at the posedge,
  // then check at the following negedge.
  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit rst);
    logic [63:0] di; logic [2:0] df; logic dl;
    bit in_fire, out_fire;
    in_valid = v; in_instr = v ? ins : 32'hxxxx_xxxx; out_ready = rdy; rst_n = !rst;
    in_fire  = v && (q.size() < 2);
    out_fire = rdy && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete(); cnt16 = 0; cnt2 = 0; fresh = 1'b1;
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        q.push_back(ins); fresh = 1'b0;
        ref_dec(ins, 32, di, df, dl);
        if (dl) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt2 < 3) cnt2++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops[12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};
    logic [31:0] r = $urandom();
    logic [6:0] op = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) op = r[6:0];
    return {r[31:7], op};
  endfunction

  logic [31:0] dv_ins[7] = '{32'hFFF00093, 32'h800002B7, 32'h00000517, 32'hFE000EE3,
                             32'h0080006F, 32'h01F09093, 32'h3401D073};
  logic [63:0] dv_imm[7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                             64'h8, 64'd31, 64'd3};
  logic [2:0]  dv_fmt[7] = '{3'd1, 3'd4, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Directed vectors with literal expectations.
    for (int k = 0; k < 7; k++) begin
      step(1, dv_ins[k], 1, 0);
      chk("dir_b_imm", b_imm, dv_imm[k]);
      chk("dir_a_imm", 64'(a_imm), {32'b0, dv_imm[k][31:0]});
      chk("dir_fmt", 64'(a_fmt), 64'(dv_fmt[k]));
      chk("dir_valid", 64'(a_ov), 64'd1);
    end
    step(0, 0, 1, 0);

    // Back-pressure: third word held until space frees up.
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    chk("hold_in_ready", 64'(a_ir), 64'd0);
    step(1, 32'h00300193, 0, 0);
    step(1, 32'h00300193, 1, 0);
    step(1, 32'h00300193, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);

    // Illegal counter saturation on the 2-bit instance.
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h0000007F, 1, 0);
      chk("sat_illegal", 64'(c_ill), 64'd1);
      chk("sat_cnt", 64'(c_cnt), (k < 3) ? 64'(k + 1) : 64'd3);
    end
    step(0, 0, 1, 0);

    // Reset with two entries buffered.
    step(1, 32'h00500293, 0, 0);
    step(1, 32'h00600313, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_valid", 64'(a_ov), 64'd0);
    chk("rst_ready", 64'(b_ir), 64'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
